// File: rtl/shift_barrel_pipe.sv
// Pipelined barrel shifter/rotator with a valid/ready handshake on both sides.
// Right-direction ops bit-reverse the operand around a shared left-shift core.
module shift_barrel_pipe #(
    parameter int unsigned Bits   = 64,
    parameter int unsigned Stages = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [Bits-1:0]         in_a,
    input  logic [$clog2(Bits)-1:0] in_sh,
    input  logic [2:0]              in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [Bits-1:0]         out_b
);
    localparam int unsigned ShW = $clog2(Bits);

    typedef enum logic [1:0] {
        FillZero,
        FillSign,
        FillWrap
    } fill_e;

    typedef struct packed {
        logic [ShW-1:0] sh;
        fill_e          fill;
        logic           rev;
        logic           sign;
    } ctl_t;

    function automatic logic [Bits-1:0] bit_rev(input logic [Bits-1:0] x);
        logic [Bits-1:0] y;
        y = '0;
        for (int j = 0; j < int'(Bits); j++) begin
            y[j] = x[int'(Bits)-1-j];
        end
        return y;
    endfunction

    // One mux level: shift left by 2^k, low bits filled with zero, sign or wrapped MSBs.
    function automatic logic [Bits-1:0] shift_level(input logic [Bits-1:0] x, input int k,
                                                    input fill_e fill, input logic sign);
        logic [Bits-1:0] y;
        int              n;
        y = '0;
        n = 1 << k;
        for (int j = 0; j < int'(Bits); j++) begin
            if (j >= n) begin
                y[j] = x[j-n];
            end else begin
                case (fill)
                    FillWrap: y[j] = x[j-n+int'(Bits)];
                    FillSign: y[j] = sign;
                    default:  y[j] = 1'b0;
                endcase
            end
        end
        return y;
    endfunction

    // Levels owned by stage s: k such that floor(k*Stages/ShW) == s.
    function automatic logic [ShW-1:0] level_mask(input int s);
        logic [ShW-1:0] m;
        m = '0;
        for (int k = 0; k < int'(ShW); k++) begin
            if ((k * int'(Stages)) / int'(ShW) == s) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

    logic [Bits-1:0]   in_data;
    ctl_t              in_ctl;
    logic [Stages-1:0] valid;
    logic [Stages-1:0] ready;

    always_comb begin
        in_data      = in_a;
        in_ctl.sh    = in_sh;
        in_ctl.fill  = FillZero;
        in_ctl.rev   = 1'b0;
        in_ctl.sign  = in_a[Bits-1];
        case (in_mode)
            3'b000: in_ctl.fill = FillWrap;
            3'b001: begin
                in_ctl.fill = FillWrap;
                in_ctl.rev  = 1'b1;
            end
            3'b010: in_ctl.fill = FillZero;
            3'b011: in_ctl.rev = 1'b1;
            3'b100: begin
                in_ctl.fill = FillSign;
                in_ctl.rev  = 1'b1;
            end
            default: in_ctl.sh = '0;
        endcase
        if (in_ctl.rev) begin
            in_data = bit_rev(in_a);
        end
    end

    // Stage s can load unless it and every stage after it is full and the sink stalls.
    always_comb begin
        for (int s = 0; s < int'(Stages); s++) begin
            ready[s] = out_ready;
            for (int t = s; t < int'(Stages); t++) begin
                if (!valid[t]) begin
                    ready[s] = 1'b1;
                end
            end
        end
    end

    assign in_ready = ready[0];

    for (genvar s = 0; s < int'(Stages); s++) begin : g_stage
        localparam logic [ShW-1:0] Mask = level_mask(s);

        logic [Bits-1:0] src_data;
        logic [Bits-1:0] nxt_data;
        logic [Bits-1:0] data_q;
        logic [ShW-1:0]  sh_here;
        ctl_t            src_ctl;
        logic            up_valid;
        logic            valid_q;

        if (s == 0) begin : g_src
            assign src_data = in_data;
            assign src_ctl  = in_ctl;
            assign up_valid = in_valid;
        end else begin : g_src
            assign src_data = g_stage[s-1].data_q;
            assign src_ctl  = g_stage[s-1].g_ctl.ctl_q;
            assign up_valid = g_stage[s-1].valid_q;
        end

        always_comb begin
            sh_here  = src_ctl.sh & Mask;
            nxt_data = src_data;
            for (int k = 0; k < int'(ShW); k++) begin
                if (sh_here[k]) begin
                    nxt_data = shift_level(nxt_data, k, src_ctl.fill, src_ctl.sign);
                end
            end
            if (s == int'(Stages) - 1 && src_ctl.rev) begin
                nxt_data = bit_rev(nxt_data);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (ready[s]) begin
                valid_q <= up_valid;
                if (up_valid) begin
                    data_q <= nxt_data;
                end
            end
        end

        assign valid[s] = valid_q;

        if (s < int'(Stages) - 1) begin : g_ctl
            ctl_t ctl_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ctl_q <= '0;
                end else if (ready[s] && up_valid) begin
                    ctl_q <= src_ctl;
                end
            end
        end
    end

    assign out_valid = g_stage[Stages-1].valid_q;
    assign out_b     = g_stage[Stages-1].data_q;

endmodule

// File: tb/tb_shift_barrel_pipe.sv
// Self-checking bench for shift_barrel_pipe (Bits=8, Stages=2) against a
// plain-arithmetic reference model.
module tb_shift_barrel_pipe;
    localparam int unsigned Bits   = 8;
    localparam int unsigned Stages = 2;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [2:0] in_sh;
    logic [2:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_b;

    int n_checks = 0;
    int n_fail   = 0;

    shift_barrel_pipe #(
        .Bits   (Bits),
        .Stages (Stages)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_sh     (in_sh),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [7:0] a, input int sh, input logic [2:0] mode);
        logic [7:0] r;
        case (mode)
            3'd0:    r = (a << sh) | (a >> (8 - sh));
            3'd1:    r = (a >> sh) | (a << (8 - sh));
            3'd2:    r = a << sh;
            3'd3:    r = a >> sh;
            3'd4:    r = $signed(a) >>> sh;
            default: r = a;
        endcase
        return r;
    endfunction

    // Drives one op into an empty pipe and reports its result and latency in cycles.
    task automatic send_single(input logic [7:0] a, input logic [2:0] sh, input logic [2:0] mode,
                               output logic [7:0] got, output int lat);
        in_a     = a;
        in_sh    = sh;
        in_mode  = mode;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = out_b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        if (out_valid !== 1'b0) n_fail++;
        n_checks++;
        if (out_b !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out_b: got %h want 00", out_b);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_release: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_rotate();
        logic [7:0] got;
        int         lat;
        out_ready = 1'b1;
        send_single(8'h81, 3'd1, 3'b000, got, lat);
        n_checks++;
        if (got !== 8'h03) begin
            n_fail++;
            $display("FAIL rol_81_1: got %h want 03", got);
        end
        n_checks++;
        if (lat != int'(Stages)) begin
            n_fail++;
            $display("FAIL rol_latency: got %0d want %0d", lat, Stages);
        end
        send_single(8'h81, 3'd1, 3'b001, got, lat);
        n_checks++;
        if (got !== 8'hC0) begin
            n_fail++;
            $display("FAIL ror_81_1: got %h want c0", got);
        end
        n_checks++;
        if (lat != int'(Stages)) begin
            n_fail++;
            $display("FAIL ror_latency: got %0d want %0d", lat, Stages);
        end
    endtask

    task automatic test_shift();
        logic [7:0] ta[4] = '{8'h90, 8'h90, 8'h90, 8'h70};
        logic [2:0] tm[4] = '{3'b010, 3'b011, 3'b100, 3'b100};
        logic [7:0] te[4] = '{8'h80, 8'h12, 8'hF2, 8'h0E};
        logic [7:0] got;
        int         lat;
        for (int i = 0; i < 4; i++) begin
            send_single(ta[i], 3'd3, tm[i], got, lat);
            n_checks++;
            if (got !== te[i] || lat != int'(Stages)) begin
                n_fail++;
                $display("FAIL shift_%0d mode=%0d a=%h: got %h lat %0d want %h lat %0d",
                         i, tm[i], ta[i], got, lat, te[i], Stages);
            end
        end
    endtask

    task automatic test_boundary();
        logic [7:0] got;
        logic [7:0] a;
        int         lat;
        for (int m = 0; m < 8; m++) begin
            a = 8'($urandom);
            send_single(a, 3'd0, 3'(m), got, lat);
            n_checks++;
            if (got !== a) begin
                n_fail++;
                $display("FAIL sh0_mode%0d: got %h want %h", m, got, a);
            end
        end
        send_single(8'h01, 3'd7, 3'b000, got, lat);
        n_checks++;
        if (got !== 8'h80) begin
            n_fail++;
            $display("FAIL rol_01_7: got %h want 80", got);
        end
        send_single(8'h5A, 3'd5, 3'b111, got, lat);
        n_checks++;
        if (got !== 8'h5A) begin
            n_fail++;
            $display("FAIL reserved_111: got %h want 5a", got);
        end
    endtask

    // Every mode x every shift amount, one op per cycle with out_ready held high.
    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] a;
        logic [7:0] e;
        int         n;
        n         = 64;
        out_ready = 1'b1;
        for (int c = 0; c < n + int'(Stages); c++) begin
            if (c >= int'(Stages)) begin
                e = q.pop_front();
                n_checks++;
                if (out_valid !== 1'b1 || out_b !== e) begin
                    n_fail++;
                    $display("FAIL stream_%0d: got valid=%b b=%h want 1 %h", c - int'(Stages),
                             out_valid, out_b, e);
                end
            end
            if (c < n) begin
                a        = 8'($urandom);
                in_a     = a;
                in_sh    = 3'(c % 8);
                in_mode  = 3'(c / 8);
                in_valid = 1'b1;
                q.push_back(model(a, c % 8, 3'(c / 8)));
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_in_ready_%0d: got %b want 1", c, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_drain: got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] q[$];
        logic [7:0] a;
        logic [7:0] e;
        logic [7:0] prev_b;
        logic [2:0] sh;
        logic [2:0] mode;
        logic       prev_stall;
        logic       exp_ready;
        int         sent;
        int         cyc;
        sent       = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_b     = '0;
        while ((sent < 10 || q.size() != 0) && cyc < 400) begin
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_b !== prev_b) begin
                    n_fail++;
                    $display("FAIL bp_hold: got valid=%b b=%h want 1 %h", out_valid, out_b, prev_b);
                end
            end
            out_ready = ($urandom_range(0, 1) == 1);
            if (sent < 10 && $urandom_range(0, 3) != 0) begin
                a        = 8'($urandom);
                sh       = 3'($urandom);
                mode     = 3'($urandom_range(0, 7));
                in_a     = a;
                in_sh    = sh;
                in_mode  = mode;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            exp_ready = (q.size() < int'(Stages)) || out_ready;
            n_checks++;
            if (in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL bp_in_ready: got %b want %b (occ %0d)", in_ready, exp_ready, q.size());
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra_output: got %h want none", out_b);
                end else begin
                    e = q.pop_front();
                    if (out_b !== e) begin
                        n_fail++;
                        $display("FAIL bp_data: got %h want %h", out_b, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, int'(sh), mode));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_b     = out_b;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (cyc >= 400) begin
            n_fail++;
            $display("FAIL bp_timeout: got %0d pending want 0", q.size());
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        in_a      = 8'hA5;
        in_sh     = 3'd2;
        in_mode   = 3'b111;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_a    = 8'($urandom);
        in_mode = 3'b000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_b !== 8'hA5) begin
            n_fail++;
            $display("FAIL rst_inflight_head: got valid=%b b=%h want 1 a5", out_valid, out_b);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_full_ready: got %b want 0", in_ready);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_b !== 8'h00 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async: got valid=%b b=%h ready=%b want 0 00 1",
                     out_valid, out_b, in_ready);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_stale_%0d: got valid=%b b=%h want 0", i, out_valid, out_b);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_sh     = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        #1;
        reset_n = 1'b0;
        test_reset();
        test_rotate();
        test_shift();
        test_boundary();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
